// File: rtl/block_data_memory_pkg.sv
// Shared definitions for block_data_memory: FSM encoding and the
// address/data width defaults used with data_cache.
package block_data_memory_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_BUSY = 2'b01;
  localparam state_t ST_DONE = 2'b10;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 32;

endpackage

// File: rtl/block_data_memory.sv
// Fixed-latency block memory behind a busywait handshake: one access is
// captured, held for LATENCY cycles, committed, then a one-cycle DONE gap.
module block_data_memory
  import block_data_memory_pkg::*;
#(
  parameter int unsigned LATENCY = 5,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_writedata,
  output logic [DATA_W-1:0] mem_readdata,
  output logic              mem_busywait
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                op_write_q, op_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   readdata_q, readdata_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic                busy;
  logic                commit;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    readdata_d = readdata_q;
    mem_d      = mem_q;
    busy       = 1'b0;
    commit     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy = mem_read | mem_write;
        if (busy) begin
          // A simultaneous read+write is treated as a write.
          op_write_d = mem_write;
          addr_d     = mem_address;
          wdata_d    = mem_writedata;
          cnt_d      = CNT_LOAD;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        busy = 1'b1;
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (commit) begin
      if (op_write_q) mem_d[addr_q] = wdata_q;
      else            readdata_d    = mem_q[addr_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      readdata_q <= '0;
      mem_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      readdata_q <= readdata_d;
      mem_q      <= mem_d;
    end
  end

  // Reset clears state asynchronously, but the IDLE term is combinational on
  // the request inputs, so it must be gated explicitly.
  assign mem_busywait = busy & ~reset;
  assign mem_readdata = readdata_q;

endmodule

// File: tb/tb_block_data_memory.sv
// Directed bench for block_data_memory with a transaction-timing reference
// model compared every cycle, plus literal expectations per scenario.
module tb_block_data_memory;

  localparam int L = 5;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  int tests_run = 0;
  int tests_failed = 0;

  block_data_memory #(.LATENCY(L), .ADDR_W(6), .DATA_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: an accepted request commits LATENCY edges after
  // acceptance, and the edge after that frees the memory again.
  logic [31:0] m_mem [64];
  logic [31:0] m_rd;
  bit          m_pending;
  int          m_cyc;
  int          m_acc;
  bit          m_op_w;
  logic [5:0]  m_addr;
  logic [31:0] m_data;

  initial begin
    logic exp_busy;
    m_pending = 0; m_cyc = 0; m_acc = 0; m_rd = '0;
    m_op_w = 0; m_addr = '0; m_data = '0;
    for (int i = 0; i < 64; i++) m_mem[i] = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        m_rd = '0;
        m_pending = 0;
      end else begin
        m_cyc++;
        if (m_pending) begin
          if (m_cyc == m_acc + L) begin
            if (m_op_w) m_mem[m_addr] = m_data;
            else        m_rd = m_mem[m_addr];
          end else if (m_cyc == m_acc + L + 1) begin
            m_pending = 0;
          end
        end else if (mem_read || mem_write) begin
          m_pending = 1;
          m_acc     = m_cyc;
          m_op_w    = mem_write;
          m_addr    = mem_address;
          m_data    = mem_writedata;
        end
      end
      @(negedge clk);
      if (reset)          exp_busy = 1'b0;
      else if (m_pending) exp_busy = (m_cyc < m_acc + L);
      else                exp_busy = mem_read | mem_write;
      check("busywait", {31'b0, mem_busywait}, {31'b0, exp_busy});
      check("readdata", mem_readdata, reset ? 32'h0 : m_rd);
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [5:0] addr,
                        input logic [31:0] data, input bit now, input int chg_at,
                        input logic [5:0] chg_addr, output int busy_n,
                        output logic [31:0] rdata);
    bit ok;
    if (now) #1;
    else begin
      @(posedge clk);
      #2;
    end
    mem_read = rd; mem_write = wr; mem_address = addr; mem_writedata = data;
    busy_n = 0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!mem_busywait) begin
        ok = 1;
        break;
      end
      busy_n++;
      if (busy_n == chg_at) begin
        #1;
        mem_address   = chg_addr;
        mem_writedata = ~data;
      end
    end
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL timeout: busywait stuck high at addr %h", addr);
    end
    rdata = mem_readdata;
  endtask

  task automatic drop_req();
    @(posedge clk);
    #2;
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    int          bn;
    logic [31:0] rdv;
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    mem_address = '0; mem_writedata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busywait", {31'b0, mem_busywait}, 32'h0);
    check("reset_readdata", mem_readdata, 32'h0);
    mem_read = 1'b1;
    #1 check("reset_busywait_req", {31'b0, mem_busywait}, 32'h0);
    mem_read = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;

    // Read after reset
    access(1, 0, 6'h05, 32'h0, 0, -1, 6'h0, bn, rdv);
    check("rd05_busy_cycles", bn, L + 1);
    check("rd05_data", rdv, 32'h0);
    drop_req();

    // Write then read back
    access(0, 1, 6'h3F, 32'hDEADBEEF, 0, -1, 6'h0, bn, rdv);
    check("wr3f_busy_cycles", bn, L + 1);
    drop_req();
    access(1, 0, 6'h3F, 32'h0, 0, -1, 6'h0, bn, rdv);
    check("rd3f_data", rdv, 32'hDEADBEEF);
    drop_req();

    // Write-back followed by fetch raised at the DONE-exit edge
    access(0, 1, 6'h08, 32'h11223344, 0, -1, 6'h0, bn, rdv);
    access(1, 0, 6'h10, 32'h0, 1, -1, 6'h0, bn, rdv);
    check("b2b_rd10_busy_cycles", bn, L + 1);
    check("b2b_rd10_data", rdv, 32'h0);
    drop_req();
    access(1, 0, 6'h08, 32'h0, 0, -1, 6'h0, bn, rdv);
    check("b2b_rd08_data", rdv, 32'h11223344);
    drop_req();

    // Simultaneous read+write acts as a write; readdata untouched
    access(1, 1, 6'h01, 32'hA5A5A5A5, 0, -1, 6'h0, bn, rdv);
    check("both_readdata_kept", rdv, 32'h11223344);
    drop_req();
    access(1, 0, 6'h01, 32'h0, 0, -1, 6'h0, bn, rdv);
    check("both_rd01_data", rdv, 32'hA5A5A5A5);
    drop_req();

    // Address change during BUSY is ignored
    access(0, 1, 6'h04, 32'h04040404, 0, -1, 6'h0, bn, rdv);
    drop_req();
    access(0, 1, 6'h07, 32'h07070707, 0, -1, 6'h0, bn, rdv);
    drop_req();
    access(1, 0, 6'h04, 32'h0, 0, 3, 6'h07, bn, rdv);
    check("addrchg_busy_cycles", bn, L + 1);
    check("addrchg_data", rdv, 32'h04040404);
    drop_req();

    // Reset in the 3rd BUSY cycle aborts a pending write
    @(posedge clk);
    #2;
    mem_write = 1'b1; mem_address = 6'h02; mem_writedata = 32'hFFFFFFFF;
    repeat (4) @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midbusy_reset_busywait", {31'b0, mem_busywait}, 32'h0);
    check("midbusy_reset_readdata", mem_readdata, 32'h0);
    mem_write = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    access(1, 0, 6'h02, 32'h0, 0, -1, 6'h0, bn, rdv);
    check("abort_rd02_data", rdv, 32'h0);
    drop_req();
    access(1, 0, 6'h3F, 32'h0, 0, -1, 6'h0, bn, rdv);
    check("reset_cleared_3f", rdv, 32'h0);
    drop_req();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/block_data_memory.md
BLOCK_DATA_MEMORY -- requirements
Module: block_data_memory

Interface
REQ-001 Parameter LATENCY, default 5, SHALL set the number of BUSY cycles per access; legal range 1..15.
REQ-002 Parameter ADDR_W, default 6, SHALL set the block address width (64 blocks).
REQ-003 Parameter DATA_W, default 32, SHALL set the block width (4 bytes).
REQ-004 clk  input  1  SHALL be the clock; all state changes occur on the rising edge.
REQ-005 reset  input  1  SHALL be asynchronous, active-high.
REQ-006 mem_read  input  1  SHALL be the block read request, held by the requester until it samples mem_busywait low.
REQ-007 mem_write  input  1  SHALL be the block write request, with the same hold rule.
REQ-008 mem_address  input  ADDR_W  SHALL be the block index.
REQ-009 mem_writedata  input  DATA_W  SHALL be the write block; byte 0 is in [7:0].
REQ-010 mem_readdata  output  DATA_W  SHALL be the registered read block.
REQ-011 mem_busywait  output  1  SHALL be the stall to the requester.

Function
REQ-012 The storage SHALL be 2^ADDR_W words of DATA_W bits.
REQ-013 The FSM SHALL have the states IDLE, BUSY and DONE.
REQ-014 In IDLE, mem_busywait SHALL equal (mem_read | mem_write) combinationally, so it is high in the same cycle the request appears.
REQ-015 At a rising edge in IDLE with a request present, the block SHALL capture the op, mem_address and mem_writedata, load the counter with LATENCY-1, and enter BUSY.
REQ-016 In BUSY, mem_busywait SHALL be 1 and the counter SHALL decrement each edge.
REQ-017 At the BUSY edge where the counter equals 0, the captured access SHALL commit and the FSM SHALL enter DONE.
REQ-018 Commit for a read SHALL load mem_readdata from the array.
REQ-019 Commit for a write SHALL store the captured data into the array.
REQ-020 In DONE, mem_busywait SHALL be 0 for exactly one cycle, and the next edge SHALL return the FSM to IDLE unconditionally.
REQ-021 End-to-end, for a request seen at edge E1, mem_busywait SHALL be low during the cycle ending at E1+LATENCY+1, and mem_readdata SHALL be valid in that cycle.
REQ-022 When mem_read and mem_write are both high at capture, the access SHALL be a write, and mem_readdata SHALL be unchanged.
REQ-023 Input changes during BUSY (drop, new address, new data) SHALL be ignored; the captured access commits regardless.
REQ-024 A request presented at the DONE-exit edge (write-back followed by fetch) SHALL be seen in IDLE in the next cycle and served with no extra idle cycle.
REQ-025 mem_readdata SHALL hold its value between read commits.
REQ-026 Address arithmetic SHALL be the index only: no wrap or offset logic, and all ADDR_W values are legal.

Reset
REQ-027 Reset SHALL force the FSM to IDLE, the counter to 0, mem_readdata to 0, all captured registers to 0, and every array word to 0.
REQ-028 While reset is high, mem_busywait SHALL be 0.
REQ-029 Reset during BUSY SHALL abort the access; a pending write SHALL NOT commit.
REQ-030 After reset deasserts, a held request SHALL be treated as new in IDLE.

Structure
REQ-031 The shared package SHALL hold the state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10) and the ADDR_W/DATA_W defaults shared with data_cache.
REQ-032 The block SHALL be a single module; a sub-module is not natural, and the counter and FSM are inline.

Verification
REQ-033 Verify reset then read: reset, then mem_read=1 at addr 6'h05 with LATENCY=5 -> busywait high for 6 cycles, then low for 1 cycle with mem_readdata=32'h0.
REQ-034 Verify write then read: write 32'hDEADBEEF to 6'h3F, then read 6'h3F -> mem_readdata=32'hDEADBEEF in the DONE cycle.
REQ-035 Verify back-to-back: write 32'h11223344 to 6'h08, with mem_read to 6'h10 raised at the DONE-exit edge -> the read enters BUSY with no gap, 6'h08 holds 32'h11223344, and the read returns the prior 6'h10 value.
REQ-036 Verify simultaneous requests: mem_read=mem_write=1 with data 32'hA5A5A5A5 at 6'h01 -> a write is performed and mem_readdata is unchanged.
REQ-037 Verify reset mid-BUSY: write 32'hFFFFFFFF to 6'h02, reset at the 3rd BUSY cycle, then read 6'h02 -> returns 32'h0 and busywait is 0 during reset.
REQ-038 Verify mid-BUSY address change: change mem_address from 6'h04 to 6'h07 during BUSY of a read -> data of 6'h04 is returned.
